// File: rtl/pesos_mac_sequencer.sv
// Weight-RAM port owner: shares the single RAM port with the Avalon host and
// runs fetch/multiply-accumulate passes that return one saturated 32-bit sum.
module pesos_mac_sequencer #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   h_address,
  input  logic                h_chipselect,
  input  logic                h_read,
  input  logic                h_write,
  input  logic [DATA_W-1:0]   h_writedata,
  input  logic [DATA_W/8-1:0] h_byteenable,
  output logic [DATA_W-1:0]   h_readdata,
  output logic                h_waitrequest,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     num_terms,
  input  logic [15:0]         x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic                busy,
  output logic                done,
  output logic                start_err,
  output logic [31:0]         result,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic [DATA_W-1:0]   ram_writedata,
  input  logic [DATA_W-1:0]   ram_readdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOST_RD,
    S_FETCH,
    S_MAC,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t                state_q, state_d;
  logic signed [39:0]    acc_q, acc_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]       limit_q, limit_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic signed [15:0]    w_q, w_d;
  logic                  first_q, first_d;
  logic [31:0]           result_q, result_d;
  logic                  start_err_q, start_err_d;

  logic                  host_rd;
  logic                  host_wr;
  logic [ADDR_W:0]       limit_in;
  logic signed [15:0]    w_cur;
  logic signed [15:0]    x_s;
  logic signed [31:0]    product;
  logic [31:0]           acc_sat;
  logic [ADDR_W:0]       cnt_inc;

  assign host_rd  = h_chipselect & h_read;
  assign host_wr  = h_chipselect & h_write;
  assign limit_in = (num_terms > DEPTH) ? DEPTH : num_terms;
  assign cnt_inc  = cnt_q + 1'b1;

  // The RAM output is only valid in the first MAC cycle; later stall cycles use the held copy.
  assign w_cur   = first_q ? ram_readdata[15:0] : w_q;
  assign x_s     = x_data;
  assign product = w_cur * x_s;

  always_comb begin
    acc_sat = acc_q[31:0];
    if (!acc_q[39] && (|acc_q[38:31])) begin
      acc_sat = 32'h7FFF_FFFF;
    end else if (acc_q[39] && !(&acc_q[38:31])) begin
      acc_sat = 32'h8000_0000;
    end
  end

  assign busy      = (state_q == S_FETCH) || (state_q == S_MAC) || (state_q == S_DONE);
  assign start_err = start_err_q;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    limit_d        = limit_q;
    base_d         = base_q;
    w_d            = w_q;
    first_d        = 1'b0;
    result_d       = result_q;
    start_err_d    = start_err_q;
    result         = result_q;
    h_readdata     = '0;
    h_waitrequest  = 1'b0;
    x_ready        = 1'b0;
    done           = 1'b0;
    ram_address    = '0;
    ram_chipselect = 1'b0;
    ram_write      = 1'b0;
    ram_byteenable = '0;
    ram_writedata  = '0;

    if (start && (state_q != S_IDLE)) begin
      start_err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d        = base_addr;
          limit_d       = limit_in;
          cnt_d         = '0;
          acc_d         = '0;
          start_err_d   = 1'b0;
          h_waitrequest = h_chipselect;
          state_d       = (limit_in == '0) ? S_DONE : S_FETCH;
        end else if (host_wr) begin
          ram_address    = h_address;
          ram_chipselect = 1'b1;
          ram_write      = 1'b1;
          ram_byteenable = h_byteenable;
          ram_writedata  = h_writedata;
        end else if (host_rd) begin
          ram_address    = h_address;
          ram_chipselect = 1'b1;
          h_waitrequest  = 1'b1;
          state_d        = S_HOST_RD;
        end
      end

      S_HOST_RD: begin
        ram_address    = h_address;
        ram_chipselect = 1'b1;
        h_readdata     = ram_readdata;
        state_d        = S_IDLE;
      end

      S_FETCH: begin
        h_waitrequest  = h_chipselect;
        ram_address    = base_q + cnt_q[ADDR_W-1:0];
        ram_chipselect = 1'b1;
        first_d        = 1'b1;
        state_d        = S_MAC;
      end

      S_MAC: begin
        h_waitrequest = h_chipselect;
        x_ready       = 1'b1;
        w_d           = w_cur;
        if (x_valid) begin
          acc_d   = acc_q + {{8{product[31]}}, product};
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == limit_q) ? S_DONE : S_FETCH;
        end
      end

      S_DONE: begin
        h_waitrequest = h_chipselect;
        done          = 1'b1;
        result        = acc_sat;
        result_d      = acc_sat;
        state_d       = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      limit_q     <= '0;
      base_q      <= '0;
      w_q         <= '0;
      first_q     <= 1'b0;
      result_q    <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      base_q      <= base_d;
      w_q         <= w_d;
      first_q     <= first_d;
      result_q    <= result_d;
      start_err_q <= start_err_d;
    end
  end

endmodule

// File: tb/tb_pesos_mac_sequencer.sv
// Self-checking bench: behavioural RAM plus a sum-of-products reference model
// derived from the pass rules, with randomized weights, samples and stalls.
module tb_pesos_mac_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  h_address;
  logic        h_chipselect, h_read, h_write;
  logic [31:0] h_writedata;
  logic [3:0]  h_byteenable;
  logic [31:0] h_readdata;
  logic        h_waitrequest;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  num_terms;
  logic [15:0] x_data;
  logic        x_valid, x_ready;
  logic        busy, done, start_err;
  logic [31:0] result;
  logic [5:0]  ram_address;
  logic        ram_chipselect, ram_write;
  logic [3:0]  ram_byteenable;
  logic [31:0] ram_writedata, ram_readdata;

  int checks = 0;
  int passes = 0;

  logic [31:0] mem [64];
  logic [5:0]  mem_addr_q = '0;
  logic [31:0] ref_mem [64];
  int          xs [64];
  int          stall [64];

  always #5 clk = ~clk;

  pesos_mac_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .h_address(h_address), .h_chipselect(h_chipselect), .h_read(h_read), .h_write(h_write),
    .h_writedata(h_writedata), .h_byteenable(h_byteenable),
    .h_readdata(h_readdata), .h_waitrequest(h_waitrequest),
    .start(start), .base_addr(base_addr), .num_terms(num_terms),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .busy(busy), .done(done), .start_err(start_err), .result(result),
    .ram_address(ram_address), .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata), .ram_readdata(ram_readdata)
  );

  // Single-port RAM: registered address, unregistered data out.
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end
      mem_addr_q <= ram_address;
    end
  end
  assign ram_readdata = mem[mem_addr_q];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int addr, input logic [31:0] data, input logic [3:0] be);
    h_chipselect = 1'b1; h_write = 1'b1; h_read = 1'b0;
    h_address = 6'(addr); h_writedata = data; h_byteenable = be;
    #4;
    checks++;
    if (h_waitrequest !== 1'b0) $display("FAIL host_write_wait addr=%0d got=%b want=0", addr, h_waitrequest);
    else passes++;
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[addr][8*b +: 8] = data[8*b +: 8];
    cyc();
    h_chipselect = 1'b0; h_write = 1'b0;
  endtask

  task automatic host_read(input int addr);
    logic [31:0] got;
    h_chipselect = 1'b1; h_read = 1'b1; h_write = 1'b0; h_address = 6'(addr);
    #4;
    checks++;
    if (h_waitrequest !== 1'b1) $display("FAIL host_read_stall addr=%0d got=%b want=1", addr, h_waitrequest);
    else passes++;
    cyc();
    #4;
    got = h_readdata;
    checks++;
    if (h_waitrequest !== 1'b0 || got !== ref_mem[addr])
      $display("FAIL host_read_data addr=%0d got=%h wait=%b want=%h wait=0", addr, got, h_waitrequest, ref_mem[addr]);
    else passes++;
    $display("host read addr=%0d data=%h", addr, got);
    cyc();
    h_chipselect = 1'b0; h_read = 1'b0;
  endtask

  // One pass: the model sums weight*x over (base+k) mod 64 for k < min(nt,64),
  // done lands in cycle 2N+1 plus every cycle the stream was held off.
  task automatic run_pass(input int base, input int nt, input int inject_c,
                          input bit hold_rd, input int rd_addr, input string tag);
    int neff, exp_done, c, tk, st_rem, done_c, got_x, busy_err, wait_err, rd_err;
    longint sum;
    logic signed [15:0] wv;
    logic [31:0] exp_res, got_res;
    int addrs[$];
    bit addr_ok;

    neff = (nt > 64) ? 64 : nt;
    sum = 0;
    exp_done = 2 * neff + 1;
    for (int k = 0; k < neff; k++) begin
      wv = ref_mem[(base + k) % 64][15:0];
      sum += longint'(wv) * longint'(xs[k]);
      exp_done += stall[k];
    end
    if (sum > 64'sd2147483647) exp_res = 32'h7FFF_FFFF;
    else if (sum < -64'sd2147483648) exp_res = 32'h8000_0000;
    else exp_res = sum[31:0];

    start = 1'b1; base_addr = 6'(base); num_terms = 7'(nt); x_valid = 1'b0;
    if (hold_rd) begin
      h_chipselect = 1'b1; h_read = 1'b1; h_write = 1'b0; h_address = 6'(rd_addr);
    end
    #4;
    if (hold_rd) begin
      checks++;
      if (h_waitrequest !== 1'b1) $display("FAIL %s start_vs_host_stall got=%b want=1", tag, h_waitrequest);
      else passes++;
    end
    cyc();
    start = 1'b0;

    c = 1; tk = 0; st_rem = stall[0]; done_c = -1; got_x = 0;
    busy_err = 0; wait_err = 0; rd_err = 0; got_res = '0;
    while (c <= 400 && done_c < 0) begin
      start = (c == inject_c);
      if (start) begin
        base_addr = 6'($urandom);
        num_terms = 7'($urandom_range(1, 64));
      end
      if (x_ready) begin
        if (st_rem > 0) begin
          x_valid = 1'b0; x_data = 16'($urandom); st_rem--;
        end else begin
          x_valid = 1'b1; x_data = (tk < 64) ? 16'(xs[tk]) : 16'h0;
        end
      end else begin
        x_valid = 1'($urandom); x_data = 16'($urandom);
      end
      #4;
      if (busy !== 1'b1) busy_err++;
      if (hold_rd && h_waitrequest !== 1'b1) wait_err++;
      if (h_readdata !== 32'h0) rd_err++;
      if (busy === 1'b1 && ram_chipselect === 1'b1 && ram_write === 1'b0) addrs.push_back(int'(ram_address));
      if (x_valid && x_ready) begin
        got_x++; tk++;
        st_rem = (tk < 64) ? stall[tk] : 0;
      end
      if (done === 1'b1) begin
        done_c = c; got_res = result;
      end
      cyc();
      c++;
    end
    start = 1'b0; x_valid = 1'b0;

    checks++;
    if (done_c != exp_done) $display("FAIL %s done_cycle got=%0d want=%0d", tag, done_c, exp_done);
    else passes++;
    checks++;
    if (got_res !== exp_res) $display("FAIL %s result got=%h want=%h", tag, got_res, exp_res);
    else passes++;
    checks++;
    if (got_x != neff) $display("FAIL %s terms_consumed got=%0d want=%0d", tag, got_x, neff);
    else passes++;
    addr_ok = (addrs.size() == neff);
    for (int k = 0; k < addrs.size() && addr_ok; k++)
      if (addrs[k] != (base + k) % 64) addr_ok = 1'b0;
    checks++;
    if (!addr_ok) $display("FAIL %s fetch_addresses got_count=%0d first=%0d want_count=%0d first=%0d",
                           tag, addrs.size(), (addrs.size() > 0) ? addrs[0] : -1, neff, base % 64);
    else passes++;
    checks++;
    if (busy_err != 0) $display("FAIL %s busy_during_pass got=%0d low cycles want=0", tag, busy_err);
    else passes++;
    checks++;
    if (rd_err != 0) $display("FAIL %s h_readdata_nonzero got=%0d cycles want=0", tag, rd_err);
    else passes++;
    if (hold_rd) begin
      checks++;
      if (wait_err != 0) $display("FAIL %s host_stall_in_pass got=%0d unstalled cycles want=0", tag, wait_err);
      else passes++;
    end

    #4;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL %s after_done got busy=%b done=%b want 0 0", tag, busy, done);
    else passes++;
    checks++;
    if (result !== exp_res) $display("FAIL %s result_hold got=%h want=%h", tag, result, exp_res);
    else passes++;
    checks++;
    if (start_err !== (inject_c > 0)) $display("FAIL %s start_err got=%b want=%b", tag, start_err, inject_c > 0);
    else passes++;
    if (hold_rd) begin
      checks++;
      if (h_waitrequest !== 1'b1) $display("FAIL %s deferred_read_stall got=%b want=1", tag, h_waitrequest);
      else passes++;
      cyc();
      #4;
      checks++;
      if (h_waitrequest !== 1'b0 || h_readdata !== ref_mem[rd_addr])
        $display("FAIL %s deferred_read got=%h wait=%b want=%h wait=0", tag, h_readdata, h_waitrequest, ref_mem[rd_addr]);
      else passes++;
      cyc();
      h_chipselect = 1'b0; h_read = 1'b0;
    end else begin
      cyc();
    end
    $display("pass %s base=%0d n=%0d result=%h done_cycle=%0d", tag, base, nt, got_res, done_c);
  endtask

  task automatic clear_stalls();
    for (int k = 0; k < 64; k++) stall[k] = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    h_chipselect = 1'b0; h_read = 1'b1;
    repeat (2) cyc();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || start_err !== 1'b0 || x_ready !== 1'b0)
      $display("FAIL reset_outputs got busy=%b done=%b result=%h start_err=%b x_ready=%b want all 0",
               busy, done, result, start_err, x_ready);
    else passes++;
    reset_n = 1'b1;
    #4;
    checks++;
    if (h_waitrequest !== 1'b0 || ram_chipselect !== 1'b0 || ram_address !== 6'h0 || ram_write !== 1'b0)
      $display("FAIL idle_ignore_host got wait=%b cs=%b addr=%0d we=%b want 0 0 0 0",
               h_waitrequest, ram_chipselect, ram_address, ram_write);
    else passes++;
    cyc();
    h_read = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_basic();
    clear_stalls();
    for (int a = 0; a < 4; a++) host_write(a, 32'(a + 1), 4'hF);
    for (int k = 0; k < 64; k++) xs[k] = 10;
    run_pass(0, 4, 0, 1'b0, 0, "basic");
    host_read(2);
  endtask

  task automatic test_reset_mid_mac();
    int n;
    clear_stalls();
    start = 1'b1; base_addr = 6'd0; num_terms = 7'd8; x_valid = 1'b0;
    cyc();
    start = 1'b0;
    n = 0;
    while (x_ready !== 1'b1 && n < 10) begin
      cyc(); n++;
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || x_ready !== 1'b0)
      $display("FAIL reset_mid_mac got busy=%b done=%b result=%h x_ready=%b want 0 0 0 0",
               busy, done, result, x_ready);
    else passes++;
    cyc();
    reset_n = 1'b1;
    cyc();
    for (int a = 0; a < 4; a++) host_read(a);
  endtask

  task automatic test_stall();
    clear_stalls();
    for (int k = 0; k < 64; k++) xs[k] = $urandom_range(0, 65535) - 32768;
    stall[1] = 5;
    run_pass(0, 4, 0, 1'b0, 0, "stall");
    clear_stalls();
  endtask

  task automatic test_wrap();
    clear_stalls();
    host_write(62, 32'd5, 4'hF);
    host_write(63, 32'hFFFF_FFFF, 4'hF);
    host_write(0, 32'd2, 4'hF);
    host_write(1, 32'd3, 4'hF);
    for (int k = 0; k < 64; k++) xs[k] = 1;
    run_pass(62, 4, 0, 1'b0, 0, "wrap");
  endtask

  task automatic test_saturate();
    clear_stalls();
    for (int a = 0; a < 64; a++) host_write(a, 32'h0000_7FFF, 4'hF);
    for (int k = 0; k < 64; k++) xs[k] = 32767;
    run_pass(0, 64, 0, 1'b0, 0, "sat_pos");
    for (int k = 0; k < 64; k++) xs[k] = -32768;
    run_pass(17, 64, 0, 1'b0, 0, "sat_neg");
  endtask

  task automatic test_clamp_and_zero();
    clear_stalls();
    for (int a = 0; a < 64; a++) host_write(a, $urandom, 4'hF);
    for (int k = 0; k < 64; k++) xs[k] = $urandom_range(0, 255) - 128;
    run_pass(5, 100, 0, 1'b0, 0, "clamp");
    run_pass(9, 0, 0, 1'b0, 0, "zero_terms");
  endtask

  task automatic test_host_contention();
    clear_stalls();
    for (int k = 0; k < 64; k++) xs[k] = $urandom_range(0, 65535) - 32768;
    stall[2] = 2;
    run_pass(10, 6, 0, 1'b1, 11, "host_contention");
    clear_stalls();
  endtask

  task automatic test_start_err();
    clear_stalls();
    for (int k = 0; k < 64; k++) xs[k] = $urandom_range(0, 65535) - 32768;
    run_pass(20, 5, 3, 1'b0, 0, "start_err");
    run_pass(21, 3, 0, 1'b0, 0, "start_err_clear");
  endtask

  task automatic test_random();
    int base, n;
    for (int r = 0; r < 6; r++) begin
      base = $urandom_range(0, 63);
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        host_write((base + k) % 64, $urandom, ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
        xs[k] = $urandom_range(0, 65535) - 32768;
        stall[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      end
      run_pass(base, n, 0, 1'b0, 0, "random");
      clear_stalls();
    end
  endtask

  initial begin
    reset_n = 1'b0;
    h_address = '0; h_chipselect = 1'b0; h_read = 1'b0; h_write = 1'b0;
    h_writedata = '0; h_byteenable = '0;
    start = 1'b0; base_addr = '0; num_terms = '0; x_data = '0; x_valid = 1'b0;
    for (int a = 0; a < 64; a++) begin
      mem[a] = '0;
      ref_mem[a] = '0;
    end
    clear_stalls();

    test_reset();
    test_basic();
    test_reset_mid_mac();
    test_stall();
    test_wrap();
    test_saturate();
    test_clamp_and_zero();
    test_host_contention();
    test_start_err();
    test_random();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached after %0d/%0d checks", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pesos_mac_sequencer.md
# pesos_mac_sequencer

- Owns the single port of the 64×32 neuron weight RAM.
- Sequences a weighted-sum (multiply-accumulate) pass: fetches weights, pairs each with a streamed input sample, accumulates, and returns one saturated 32-bit result.
- Arbitrates the RAM port with the HPS Avalon host, so weights can be loaded or inspected while no pass is running.
- Sits between the Avalon host interconnect, the neuron input stream and the weight RAM.

## Interface
- ADDR_W, 6: weight RAM address width (depth 2^ADDR_W = 64)
- DATA_W, 32: RAM word width; weight = signed bits [15:0] of each word
- clk  in  1  system clock, all logic on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- h_address  in  6  host word address
- h_chipselect, h_read, h_write  in  1 each  host Avalon strobes
- h_writedata  in  32  host write data
- h_byteenable  in  4  host byte enables
- h_readdata  out  32  host read data
- h_waitrequest  out  1  host stall
- start  in  1  one-cycle pulse that launches a pass
- base_addr  in  6  first weight address, sampled with start
- num_terms  in  7  number of terms, sampled with start; 0..64, values >64 clamp to 64
- x_data  in  16  signed input sample
- x_valid  in  1  input-stream valid
- x_ready  out  1  input-stream ready
- busy  out  1  pass in progress
- done  out  1  one-cycle completion pulse
- start_err  out  1  sticky: start was dropped
- result  out  32  signed saturated sum
- ram_address  out  6  RAM address
- ram_chipselect, ram_write  out  1 each  RAM strobes
- ram_byteenable  out  4  RAM byte enables
- ram_writedata  out  32  RAM write data
- ram_readdata  in  32  RAM read data; valid one cycle after the address (address registered, output unregistered)

## Operation
- States: IDLE, HOST_RD, FETCH, MAC, DONE.
- Reset (async) forces IDLE and clears the accumulator, term counter, busy, done, start_err, result and x_ready to 0. RAM contents are untouched.
- IDLE:
  - start=1: capture base_addr; capture clamp(num_terms) into the counter limit; clear the accumulator and start_err; go to FETCH. If the limit is 0, go straight to DONE.
  - start wins over a same-cycle host request; the host stalls.
  - Host write, no start: pass h_* straight to ram_*, h_waitrequest=0, stay IDLE.
  - Host read, no start: drive ram_address=h_address, h_waitrequest=1, go to HOST_RD.
- HOST_RD: ram_address=h_address, h_readdata=ram_readdata, h_waitrequest=0, go to IDLE.
- FETCH: ram_address = (base + i) mod 64, where i is the term index; wrap-around is legal. ram_chipselect=1, ram_write=0. Go to MAC.
- MAC:
  - Weight w = signed ram_readdata[15:0], held in a register.
  - Hold x_ready=1 until x_valid; no timeout.
  - On x_valid&x_ready: acc += w × x_data (signed 16×16 → 32-bit product, 40-bit signed accumulator; 64 terms cannot overflow it); i++.
  - Then, if i equals the limit, go to DONE; otherwise go to FETCH.
- DONE: done=1; result = acc saturated to [−2^31, 2^31−1]; go to IDLE.
- busy = state ∈ {FETCH, MAC, DONE}.
- h_waitrequest=1 in any cycle where h_chipselect=1 and the host is not granted. This covers all busy states and the first cycle of a read.
- start while not IDLE: dropped, and start_err is set. start_err clears on the next accepted start.
- Host strobes are ignored when h_chipselect=0.
- h_readdata=0 outside HOST_RD.
- Idle RAM outputs are 0.

## Timing
- start sampled at edge 0 → FETCH in cycle 1 → MAC in cycle 2.
- With x_valid held high, term k (0-based) is accumulated at the end of cycle 2+2k.
- done and result are valid in cycle 2N+1; busy falls in cycle 2N+2.
- N=0: done in cycle 1, result=0.
- Host read takes 2 cycles when idle; host write takes 1.
- result holds its value until the next DONE.

## Test plan
- Load RAM[0..3] = 1, 2, 3, 4 via host writes; start base=0, N=4, x=10, 10, 10, 10 with x_valid constant → done in cycle 9, result=100, busy high in cycles 1–9.
- Host write 0x0000_7FFF to all 64 words; start N=64, x=32767 on every term → result = 0x7FFF_FFFF (saturated). Repeat with x=−32768 → result = 0x8000_0000.
- Wrap-around:
  - setup: base=62, N=4, weights RAM[62,63,0,1] = 5, −1, 2, 3, x=1 each;
  - required address sequence: 62, 63, 0, 1;
  - required result: 9.
- x_valid stalled for 5 cycles on term 1 → x_ready stays 1, the accumulator is unchanged until the handshake, and done is delayed by exactly 5 cycles.
- Host read issued during a pass → h_waitrequest=1 until the pass reaches IDLE; after that the read returns the correct data with one stall cycle. Same-cycle start+host read in IDLE → the pass proceeds and the host stalls.
- start pulsed mid-pass → start_err=1 and the pass result is unaffected.
- reset_n low mid-MAC → busy, done and result go to 0 immediately; RAM contents are intact on a subsequent host read.
- num_terms=100 → clamped: exactly 64 terms are consumed.
